// File: rtl/rs_logical.sv
// Reservation station feeding the logical FU: compacting age-ordered queue with CDB wakeup.
// Optional macro RS_LOGICAL_WAKEUP_BYPASS_EN lets a same-cycle CDB match make an entry eligible.
module rs_logical #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PRN_W = 7,
  parameter int unsigned ID_W  = 6,
  parameter int unsigned CDB_N = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_inst,
  input  logic [ID_W-1:0]               in_inst_id,
  input  logic [3*PRN_W-1:0]            in_src_prn,
  input  logic [2:0]                    in_src_rdy,
  input  logic [3*64-1:0]               in_src_data,
  input  logic [3*PRN_W-1:0]            in_out_prn,
  input  logic [2:0]                    in_out_prn_valid,
  input  logic [CDB_N-1:0]              cdb_valid,
  input  logic [CDB_N*PRN_W-1:0]        cdb_prn,
  input  logic [CDB_N*64-1:0]           cdb_data,
  input  logic                          fu_ready,
  output logic                          issue_valid,
  output logic [31:0]                   issue_inst,
  output logic [ID_W-1:0]               issue_inst_id,
  output logic [3*64-1:0]               issue_op,
  output logic [3*PRN_W-1:0]            issue_out_prn,
  output logic [2:0]                    issue_out_prn_valid,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]        inst_q  [DEPTH];
  logic [31:0]        inst_d  [DEPTH];
  logic [ID_W-1:0]    id_q    [DEPTH];
  logic [ID_W-1:0]    id_d    [DEPTH];
  logic [3*PRN_W-1:0] prn_q   [DEPTH];
  logic [3*PRN_W-1:0] prn_d   [DEPTH];
  logic [2:0]         rdy_q   [DEPTH];
  logic [2:0]         rdy_d   [DEPTH];
  logic [3*64-1:0]    data_q  [DEPTH];
  logic [3*64-1:0]    data_d  [DEPTH];
  logic [3*PRN_W-1:0] oprn_q  [DEPTH];
  logic [3*PRN_W-1:0] oprn_d  [DEPTH];
  logic [2:0]         oprnv_q [DEPTH];
  logic [2:0]         oprnv_d [DEPTH];

  logic [2:0]         wk_rdy  [DEPTH];
  logic [3*64-1:0]    wk_data [DEPTH];
  logic [2:0]         disp_rdy;
  logic [3*64-1:0]    disp_data;

  logic [CNT_W-1:0]   count_q, count_d, wr_idx;
  logic [DEPTH-1:0]   elig;
  logic [IDX_W-1:0]   sel;
  logic               found, do_issue, do_disp;

  logic               issue_valid_q, issue_valid_d;
  logic [31:0]        issue_inst_q, issue_inst_d;
  logic [ID_W-1:0]    issue_id_q, issue_id_d;
  logic [3*64-1:0]    issue_op_q, issue_op_d;
  logic [3*PRN_W-1:0] issue_oprn_q, issue_oprn_d;
  logic [2:0]         issue_oprnv_q, issue_oprnv_d;

  assign in_ready            = (count_q < CNT_W'(DEPTH));
  assign count               = count_q;
  assign issue_valid         = issue_valid_q;
  assign issue_inst          = issue_inst_q;
  assign issue_inst_id       = issue_id_q;
  assign issue_op            = issue_op_q;
  assign issue_out_prn       = issue_oprn_q;
  assign issue_out_prn_valid = issue_oprnv_q;

  // CDB capture for stored entries and the incoming dispatch; descending scan lets port 0 win
  always_comb begin
    disp_rdy  = in_src_rdy;
    disp_data = in_src_data;
    for (int i = 0; i < DEPTH; i++) begin
      wk_rdy[i]  = rdy_q[i];
      wk_data[i] = data_q[i];
    end
    for (int s = 0; s < 3; s++) begin
      for (int p = int'(CDB_N) - 1; p >= 0; p--) begin
        if (!in_src_rdy[s] && cdb_valid[p] &&
            cdb_prn[p*PRN_W +: PRN_W] == in_src_prn[s*PRN_W +: PRN_W]) begin
          disp_rdy[s]            = 1'b1;
          disp_data[s*64 +: 64]  = cdb_data[p*64 +: 64];
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (!rdy_q[i][s] && cdb_valid[p] &&
              cdb_prn[p*PRN_W +: PRN_W] == prn_q[i][s*PRN_W +: PRN_W]) begin
            wk_rdy[i][s]             = 1'b1;
            wk_data[i][s*64 +: 64]   = cdb_data[p*64 +: 64];
          end
        end
      end
    end
  end

  // Oldest-first selection among entries whose operands are all present
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_LOGICAL_WAKEUP_BYPASS_EN
      elig[i] = (CNT_W'(i) < count_q) && (&wk_rdy[i]);
`else
      elig[i] = (CNT_W'(i) < count_q) && (&rdy_q[i]);
`endif
      if (elig[i] && !found) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  assign do_issue = fu_ready & found;
  assign do_disp  = in_valid & in_ready;
  assign wr_idx   = count_q - CNT_W'(do_issue);
  assign count_d  = count_q - CNT_W'(do_issue) + CNT_W'(do_disp);

  // Compaction above the issued slot, then dispatch write at the post-shift tail
  always_comb begin
    for (int j = 0; j < DEPTH - 1; j++) begin
      if (do_issue && IDX_W'(j) >= sel) begin
        inst_d[j] = inst_q[j+1];  id_d[j]   = id_q[j+1];    prn_d[j]   = prn_q[j+1];
        rdy_d[j]  = wk_rdy[j+1];  data_d[j] = wk_data[j+1]; oprn_d[j]  = oprn_q[j+1];
        oprnv_d[j] = oprnv_q[j+1];
      end else begin
        inst_d[j] = inst_q[j];    id_d[j]   = id_q[j];      prn_d[j]   = prn_q[j];
        rdy_d[j]  = wk_rdy[j];    data_d[j] = wk_data[j];   oprn_d[j]  = oprn_q[j];
        oprnv_d[j] = oprnv_q[j];
      end
    end
    inst_d[DEPTH-1]  = inst_q[DEPTH-1];
    id_d[DEPTH-1]    = id_q[DEPTH-1];
    prn_d[DEPTH-1]   = prn_q[DEPTH-1];
    rdy_d[DEPTH-1]   = wk_rdy[DEPTH-1];
    data_d[DEPTH-1]  = wk_data[DEPTH-1];
    oprn_d[DEPTH-1]  = oprn_q[DEPTH-1];
    oprnv_d[DEPTH-1] = oprnv_q[DEPTH-1];
    for (int j = 0; j < DEPTH; j++) begin
      if (do_disp && CNT_W'(j) == wr_idx) begin
        inst_d[j]  = in_inst;
        id_d[j]    = in_inst_id;
        prn_d[j]   = in_src_prn;
        rdy_d[j]   = disp_rdy;
        data_d[j]  = disp_data;
        oprn_d[j]  = in_out_prn;
        oprnv_d[j] = in_out_prn_valid;
      end
    end
  end

  always_comb begin
    issue_valid_d = do_issue;
    issue_inst_d  = issue_inst_q;
    issue_id_d    = issue_id_q;
    issue_op_d    = issue_op_q;
    issue_oprn_d  = issue_oprn_q;
    issue_oprnv_d = issue_oprnv_q;
    if (do_issue) begin
      issue_inst_d  = inst_q[sel];
      issue_id_d    = id_q[sel];
      issue_op_d    = wk_data[sel];
      issue_oprn_d  = oprn_q[sel];
      issue_oprnv_d = oprnv_q[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_inst_q  <= '0;
      issue_id_q    <= '0;
      issue_op_q    <= '0;
      issue_oprn_q  <= '0;
      issue_oprnv_q <= '0;
    end else begin
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_inst_q  <= issue_inst_d;
      issue_id_q    <= issue_id_d;
      issue_op_q    <= issue_op_d;
      issue_oprn_q  <= issue_oprn_d;
      issue_oprnv_q <= issue_oprnv_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked solely by count_q
  always_ff @(posedge clk) begin
    inst_q  <= inst_d;
    id_q    <= id_d;
    prn_q   <= prn_d;
    rdy_q   <= rdy_d;
    data_q  <= data_d;
    oprn_q  <= oprn_d;
    oprnv_q <= oprnv_d;
  end

endmodule

// File: tb/tb_rs_logical.sv
// Self-checking bench for rs_logical: directed scenarios plus randomized traffic vs a queue model.
module tb_rs_logical;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PRN_W = 7;
  localparam int unsigned ID_W  = 6;
  localparam int unsigned CDB_N = 2;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                   clk, rst, flush, in_valid, in_ready, fu_ready;
  logic [31:0]            in_inst;
  logic [ID_W-1:0]        in_inst_id;
  logic [3*PRN_W-1:0]     in_src_prn, in_out_prn;
  logic [2:0]             in_src_rdy, in_out_prn_valid;
  logic [3*64-1:0]        in_src_data;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*PRN_W-1:0] cdb_prn;
  logic [CDB_N*64-1:0]    cdb_data;
  logic                   issue_valid;
  logic [31:0]            issue_inst;
  logic [ID_W-1:0]        issue_inst_id;
  logic [3*64-1:0]        issue_op;
  logic [3*PRN_W-1:0]     issue_out_prn;
  logic [2:0]             issue_out_prn_valid;
  logic [CNT_W-1:0]       count;

  rs_logical #(.DEPTH(DEPTH), .PRN_W(PRN_W), .ID_W(ID_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_inst_id(in_inst_id), .in_src_prn(in_src_prn),
    .in_src_rdy(in_src_rdy), .in_src_data(in_src_data), .in_out_prn(in_out_prn),
    .in_out_prn_valid(in_out_prn_valid), .cdb_valid(cdb_valid), .cdb_prn(cdb_prn),
    .cdb_data(cdb_data), .fu_ready(fu_ready), .issue_valid(issue_valid),
    .issue_inst(issue_inst), .issue_inst_id(issue_inst_id), .issue_op(issue_op),
    .issue_out_prn(issue_out_prn), .issue_out_prn_valid(issue_out_prn_valid), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]        inst;
    logic [ID_W-1:0]    id;
    logic [3*PRN_W-1:0] prn;
    logic [2:0]         rdy;
    logic [3*64-1:0]    data;
    logic [3*PRN_W-1:0] oprn;
    logic [2:0]         oprnv;
  } ent_t;

  ent_t               mq[$];
  ent_t               m_e;
  int                 m_sel;
  bit                 m_full;
  logic               m_valid;
  logic [31:0]        m_inst;
  logic [ID_W-1:0]    m_id;
  logic [3*64-1:0]    m_op;
  logic [3*PRN_W-1:0] m_oprn;
  logic [2:0]         m_oprnv;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  int issued[$];
  int exp_ids[4];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Lowest-numbered matching CDB port supplies the value
  function automatic ent_t wake(input ent_t e);
    for (int s = 0; s < 3; s++)
      for (int p = 0; p < CDB_N; p++)
        if (!e.rdy[s] && cdb_valid[p] && cdb_prn[p*PRN_W +: PRN_W] == e.prn[s*PRN_W +: PRN_W]) begin
          e.rdy[s] = 1'b1;
          e.data[s*64 +: 64] = cdb_data[p*64 +: 64];
        end
    return e;
  endfunction

  function automatic bit ready_now(input ent_t e);
`ifdef RS_LOGICAL_WAKEUP_BYPASS_EN
    ent_t w;
    w = wake(e);
    return &w.rdy;
`else
    return &e.rdy;
`endif
  endfunction

  // Reference model: queue of pending instructions, oldest at the front
  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
      m_valid = 0; m_inst = '0; m_id = '0; m_op = '0; m_oprn = '0; m_oprnv = '0;
    end else begin
      m_full = (mq.size() >= DEPTH);
      m_sel  = -1;
      for (int i = 0; i < mq.size(); i++)
        if (m_sel < 0 && ready_now(mq[i])) m_sel = i;
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
      if (fu_ready && m_sel >= 0) begin
        m_e = mq[m_sel];
        m_valid = 1; m_inst = m_e.inst; m_id = m_e.id; m_op = m_e.data;
        m_oprn = m_e.oprn; m_oprnv = m_e.oprnv;
        mq.delete(m_sel);
      end else begin
        m_valid = 0;
      end
      if (in_valid && !m_full) begin
        m_e.inst = in_inst; m_e.id = in_inst_id; m_e.prn = in_src_prn; m_e.rdy = in_src_rdy;
        m_e.data = in_src_data; m_e.oprn = in_out_prn; m_e.oprnv = in_out_prn_valid;
        mq.push_back(wake(m_e));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 192'(count), 192'(mq.size()));
      chk("in_ready", 192'(in_ready), 192'(mq.size() < DEPTH));
      chk("issue_valid", 192'(issue_valid), 192'(m_valid));
      chk("issue_inst", 192'(issue_inst), 192'(m_inst));
      chk("issue_inst_id", 192'(issue_inst_id), 192'(m_id));
      chk("issue_op", issue_op, m_op);
      chk("issue_out_prn", 192'(issue_out_prn), 192'(m_oprn));
      chk("issue_out_prn_valid", 192'(issue_out_prn_valid), 192'(m_oprnv));
      if (issue_valid) issued.push_back(int'(issue_inst_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; cdb_valid = '0; flush = 0;
  endtask

  function automatic logic [3*PRN_W-1:0] prn3(input int a, input int b, input int c);
    return {PRN_W'(c), PRN_W'(b), PRN_W'(a)};
  endfunction

  task automatic disp(input int id, input logic [2:0] rdy, input logic [3*PRN_W-1:0] prn,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                      input int oprn0);
    in_valid = 1; in_inst = 32'h0A00_0000 + 32'(id); in_inst_id = ID_W'(id);
    in_src_prn = prn; in_src_rdy = rdy; in_src_data = {d2, d1, d0};
    in_out_prn = {PRN_W'(0), PRN_W'(0), PRN_W'(oprn0)}; in_out_prn_valid = 3'b001;
  endtask

  task automatic settle();
    idle();
    tick(); tick();
    issued.delete();
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; fu_ready = 0; cdb_valid = '0; cdb_prn = '0; cdb_data = '0;
    in_inst = '0; in_inst_id = '0; in_src_prn = '0; in_src_rdy = 3'b111; in_src_data = '0;
    in_out_prn = '0; in_out_prn_valid = '0;

    // Reset, then an all-ready ORR
    tick(); tick();
    chk_en = 1;
    chk("rst_count", 192'(count), 192'(0));
    chk("rst_issue_valid", 192'(issue_valid), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(1));
    rst = 0; fu_ready = 1;
    disp(5, 3'b111, prn3(1, 2, 3), 64'h0F, 64'hF0, 64'h0, 9);
    tick();
    idle();
    tick();
    chk("orr_valid", 192'(issue_valid), 192'(1));
    chk("orr_id", 192'(issue_inst_id), 192'(5));
    chk("orr_op0", 192'(issue_op[63:0]), 192'(64'h0F));
    chk("orr_op1", 192'(issue_op[127:64]), 192'(64'hF0));
    chk("orr_oprn0", 192'(issue_out_prn[PRN_W-1:0]), 192'(9));
    settle();

    // CDB wakeup of src1
    disp(6, 3'b101, prn3(1, 12, 3), 64'h11, 64'h0, 64'h0, 10);
    tick();
    idle();
    cdb_valid = 2'b10; cdb_prn = {PRN_W'(12), PRN_W'(0)}; cdb_data = {64'hAAAA, 64'h0};
    tick();
    idle();
`ifdef RS_LOGICAL_WAKEUP_BYPASS_EN
    chk("wake_latency", 192'(issue_valid), 192'(1));
`else
    chk("wake_early", 192'(issue_valid), 192'(0));
    tick();
    chk("wake_latency", 192'(issue_valid), 192'(1));
`endif
    chk("wake_op1", 192'(issue_op[127:64]), 192'(64'hAAAA));
    chk("wake_id", 192'(issue_inst_id), 192'(6));
    settle();

    // Age order with a blocked oldest entry
    disp(1, 3'b110, prn3(20, 2, 3), 64'h0, 64'h1, 64'h2, 11); tick();
    disp(2, 3'b111, prn3(4, 5, 6), 64'h3, 64'h4, 64'h5, 12);  tick();
    disp(3, 3'b111, prn3(4, 5, 6), 64'h6, 64'h7, 64'h8, 13);  tick();
    idle(); tick(); tick(); tick();
    cdb_valid = 2'b01; cdb_prn = {PRN_W'(0), PRN_W'(20)}; cdb_data = {64'h0, 64'h2020};
    tick();
    idle(); tick(); tick(); tick(); tick();
    chk("age_count", 192'(count), 192'(0));
    chk("age_n", 192'(issued.size()), 192'(3));
    exp_ids = '{2, 3, 1, 0};
    for (int i = 0; i < 3; i++)
      chk("age_order", 192'((i < issued.size()) ? issued[i] : -1), 192'(exp_ids[i]));
    settle();

    // Full queue and backpressure
    fu_ready = 0;
    for (int k = 0; k < 4; k++) begin
      disp(10 + k, 3'b111, prn3(1, 2, 3), 64'(k), 64'(k + 1), 64'h0, 14);
      tick();
    end
    chk("full_count", 192'(count), 192'(4));
    chk("full_in_ready", 192'(in_ready), 192'(0));
    disp(14, 3'b111, prn3(1, 2, 3), 64'h9, 64'h9, 64'h0, 15);
    tick();
    chk("full_ignored", 192'(count), 192'(4));
    idle(); fu_ready = 1;
    tick();
    chk("drain_first", 192'(issue_inst_id), 192'(10));
    chk("drain_in_ready", 192'(in_ready), 192'(1));
    tick(); tick(); tick(); tick(); tick();
    exp_ids = '{10, 11, 12, 13};
    chk("drain_n", 192'(issued.size()), 192'(4));
    for (int i = 0; i < 4; i++)
      chk("drain_order", 192'((i < issued.size()) ? issued[i] : -1), 192'(exp_ids[i]));
    settle();

    // Capture from CDB in the dispatch cycle
    disp(20, 3'b110, prn3(7, 2, 3), 64'h0, 64'h55, 64'h0, 16);
    cdb_valid = 2'b01; cdb_prn = {PRN_W'(0), PRN_W'(7)}; cdb_data = {64'h0, 64'h1234};
    tick();
    idle();
    tick();
    chk("cap_valid", 192'(issue_valid), 192'(1));
    chk("cap_op0", 192'(issue_op[63:0]), 192'(64'h1234));
    settle();

    // Flush with an issue in flight and a coinciding dispatch
    fu_ready = 0;
    for (int k = 0; k < 3; k++) begin
      disp(30 + k, 3'b111, prn3(1, 2, 3), 64'(k), 64'h0, 64'h0, 17);
      tick();
    end
    idle(); fu_ready = 1;
    tick();
    chk("pre_flush_issue", 192'(issue_valid), 192'(1));
    chk("pre_flush_id", 192'(issue_inst_id), 192'(30));
    flush = 1;
    disp(33, 3'b111, prn3(1, 2, 3), 64'h0, 64'h0, 64'h0, 18);
    tick();
    issued.delete();
    chk("flush_count", 192'(count), 192'(0));
    chk("flush_issue_valid", 192'(issue_valid), 192'(0));
    idle();
    for (int k = 0; k < 6; k++) tick();
    chk("flush_no_issue", 192'(issued.size()), 192'(0));
    settle();

    // Randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      flush    = ($urandom_range(0, 63) == 0);
      fu_ready = ($urandom_range(0, 9) < 7);
      in_valid = ($urandom_range(0, 9) < 6);
      in_inst  = $urandom;
      in_inst_id = ID_W'($urandom);
      in_src_prn = prn3($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      in_src_rdy = 3'($urandom);
      in_src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_out_prn = 21'($urandom);
      in_out_prn_valid = 3'($urandom);
      for (int p = 0; p < CDB_N; p++) begin
        cdb_valid[p] = $urandom_range(0, 1) == 1;
        cdb_prn[p*PRN_W +: PRN_W] = PRN_W'($urandom_range(0, 15));
        cdb_data[p*64 +: 64] = {$urandom, $urandom};
      end
      tick();
    end
    idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
